// File: rtl/sensor_debouncer.sv
// Sensor input conditioning: two-flop synchroniser followed by a counting debouncer
// that emits a clean level plus one-cycle load/rise/fall strobes on each accepted change.
module sensor_debouncer #(
    parameter bit INI             = 1'b0,
    parameter bit INVERT          = 1'b0,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_in,
    output logic out_d,
    output logic out_load,
    output logic out_rise,
    output logic out_fall,
    output logic out_busy
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } state_t;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic   sync1_q, sync2_q;
    state_t state_q, state_d;
    logic   [CW-1:0] cnt_q, cnt_d;
    logic   stable_q, stable_d;
    logic   load_q, load_d;
    logic   rise_q, rise_d;
    logic   fall_q, fall_d;
    logic   busy_q, busy_d;
    logic   accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= INI;
            sync2_q <= INI;
        end else begin
            sync1_q <= sensor_in ^ INVERT;
            sync2_q <= sync1_q;
        end
    end

    // A single-cycle window accepts straight from STABLE, so COUNTING is never entered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        load_d   = 1'b0;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        accept   = 1'b0;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync2_q != stable_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        accept = 1'b1;
                    end else begin
                        state_d = ST_COUNTING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_COUNTING: begin
                if (sync2_q == stable_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
        if (accept) begin
            stable_d = sync2_q;
            load_d   = 1'b1;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
            cnt_d    = '0;
            state_d  = ST_STABLE;
        end
        busy_d = (state_d == ST_COUNTING);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_STABLE;
            cnt_q    <= '0;
            stable_q <= INI;
            load_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            load_q   <= load_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            busy_q   <= busy_d;
        end
    end

    assign out_d    = stable_q;
    assign out_load = load_q;
    assign out_rise = rise_q;
    assign out_fall = fall_q;
    assign out_busy = busy_q;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Scoreboard bench for sensor_debouncer: three instances (window 4, window 1, inverted
// active-low with INI=1); expected strobes are queued at stimulus time and popped by monitors.
module tb_sensor_debouncer;

    typedef struct {
        int at;
        bit d;
        bit rise;
        bit fall;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: window 4, INI 0
    logic rst4_n, s4, d4, ld4, r4, f4, b4;
    sensor_debouncer #(.INI(1'b0), .INVERT(1'b0), .DEBOUNCE_CYCLES(4)) u4 (
        .clk(clk), .rst_n(rst4_n), .sensor_in(s4), .out_d(d4), .out_load(ld4),
        .out_rise(r4), .out_fall(f4), .out_busy(b4));

    // Instance B: window 1
    logic rst1_n, s1, d1, ld1, r1, f1, b1;
    sensor_debouncer #(.INI(1'b0), .INVERT(1'b0), .DEBOUNCE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst1_n), .sensor_in(s1), .out_d(d1), .out_load(ld1),
        .out_rise(r1), .out_fall(f1), .out_busy(b1));

    // Instance C: active-low sensor, idle level 1
    logic rsti_n, si, di, ldi, ri, fi, bi;
    sensor_debouncer #(.INI(1'b1), .INVERT(1'b1), .DEBOUNCE_CYCLES(4)) ui (
        .clk(clk), .rst_n(rsti_n), .sensor_in(si), .out_d(di), .out_load(ldi),
        .out_rise(ri), .out_fall(fi), .out_busy(bi));

    exp_t q4[$], q1[$], qi[$];
    exp_t e4, e1, ei;
    logic prev_ld4 = 1'b0, prev_ldi = 1'b0;
    bit   busy1_seen = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at_drive();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ld4 === 1'b1) begin
            if (q4.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL u4_spurious_strobe: got load at cycle %0d, expected none", cyc);
            end else begin
                e4 = q4.pop_front();
                check("u4_strobe_cycle", cyc, e4.at);
                check("u4_d", int'(d4), int'(e4.d));
                check("u4_rise", int'(r4), int'(e4.rise));
                check("u4_fall", int'(f4), int'(e4.fall));
            end
            if (prev_ld4 === 1'b1) check("u4_consecutive_strobe", 1, 0);
        end
        prev_ld4 <= ld4;
    end

    always @(negedge clk) begin
        if (b1 === 1'b1) busy1_seen <= 1'b1;
        if (ld1 === 1'b1) begin
            if (q1.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL u1_spurious_strobe: got load at cycle %0d, expected none", cyc);
            end else begin
                e1 = q1.pop_front();
                check("u1_strobe_cycle", cyc, e1.at);
                check("u1_d", int'(d1), int'(e1.d));
                check("u1_rise", int'(r1), int'(e1.rise));
                check("u1_fall", int'(f1), int'(e1.fall));
            end
        end
    end

    always @(negedge clk) begin
        if (ldi === 1'b1) begin
            if (qi.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL ui_spurious_strobe: got load at cycle %0d, expected none", cyc);
            end else begin
                ei = qi.pop_front();
                check("ui_strobe_cycle", cyc, ei.at);
                check("ui_d", int'(di), int'(ei.d));
                check("ui_rise", int'(ri), int'(ei.rise));
                check("ui_fall", int'(fi), int'(ei.fall));
            end
            if (prev_ldi === 1'b1) check("ui_consecutive_strobe", 1, 0);
        end
        prev_ldi <= ldi;
    end

    initial begin
        int  e0;
        bit  busy_seen;
        bit  d_moved;

        rst4_n = 1'b0; rst1_n = 1'b0; rsti_n = 1'b0;
        s4 = 1'b0; s1 = 1'b0; si = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_u4_d", int'(d4), 0);
        check("rst_u4_strobes", int'({ld4, r4, f4, b4}), 0);
        check("rst_u1_d", int'(d1), 0);
        check("rst_ui_d", int'(di), 1);
        check("rst_ui_strobes", int'({ldi, ri, fi, bi}), 0);
        at_drive();
        rst4_n = 1'b1; rst1_n = 1'b1; rsti_n = 1'b1;
        repeat (8) at_drive();
        check("idle_ui_d", int'(di), 1);

        // 3-cycle high glitch on the window-4 instance
        s4 = 1'b1;
        repeat (3) at_drive();
        s4 = 1'b0;
        busy_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (b4) busy_seen = 1'b1;
        end
        check("glitch_busy_pulsed", int'(busy_seen), 1);
        check("glitch_d_held", int'(d4), 0);

        // 0->1 held: accept after E5, busy after E2..E4
        at_drive();
        s4 = 1'b1;
        e0 = cyc + 1;
        q4.push_back('{at: e0 + 5, d: 1'b1, rise: 1'b1, fall: 1'b0});
        for (int k = 0; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("rise_busy_E%0d", k), int'(b4), int'(k >= 2 && k <= 4));
        end
        check("rise_strobes_clear_E6", int'({ld4, r4, f4}), 0);
        check("rise_d_held_E6", int'(d4), 1);

        // 1->0 held
        at_drive();
        s4 = 1'b0;
        e0 = cyc + 1;
        q4.push_back('{at: e0 + 5, d: 1'b0, rise: 1'b0, fall: 1'b1});
        repeat (10) at_drive();
        check("fall_d", int'(d4), 0);

        // reset pulsed mid-count, change re-debounced after release
        s4 = 1'b1;
        repeat (3) at_drive();
        check("midcount_busy", int'(b4), 1);
        rst4_n = 1'b0;
        #1;
        check("async_rst_d", int'(d4), 0);
        check("async_rst_busy", int'(b4), 0);
        check("async_rst_load", int'(ld4), 0);
        repeat (2) at_drive();
        rst4_n = 1'b1;
        e0 = cyc + 1;
        q4.push_back('{at: e0 + 5, d: 1'b1, rise: 1'b1, fall: 1'b0});
        repeat (10) at_drive();
        check("rerun_d", int'(d4), 1);

        // toggle every cycle for 50 cycles: no strobe, level unchanged
        d_moved = 1'b0;
        for (int k = 0; k < 50; k++) begin
            at_drive();
            s4 = ~s4;
            if (d4 !== 1'b1) d_moved = 1'b1;
        end
        repeat (10) at_drive();
        check("toggle_d_constant", int'(d_moved), 0);
        check("toggle_d_final", int'(d4), 1);

        // window 1: step up then step down, strobe after E2
        s1 = 1'b1;
        e0 = cyc + 1;
        q1.push_back('{at: e0 + 2, d: 1'b1, rise: 1'b1, fall: 1'b0});
        repeat (6) at_drive();
        check("w1_d_high", int'(d1), 1);
        s1 = 1'b0;
        e0 = cyc + 1;
        q1.push_back('{at: e0 + 2, d: 1'b0, rise: 1'b0, fall: 1'b1});
        repeat (6) at_drive();
        check("w1_d_low", int'(d1), 0);
        check("w1_busy_never", int'(busy1_seen), 0);

        // inverted sensor: out_d follows ~sensor_in
        si = 1'b1;
        e0 = cyc + 1;
        qi.push_back('{at: e0 + 5, d: 1'b0, rise: 1'b0, fall: 1'b1});
        repeat (10) at_drive();
        check("inv_d_low", int'(di), 0);
        si = 1'b0;
        e0 = cyc + 1;
        qi.push_back('{at: e0 + 5, d: 1'b1, rise: 1'b1, fall: 1'b0});
        repeat (10) at_drive();
        check("inv_d_high", int'(di), 1);

        repeat (4) at_drive();
        check("u4_expected_left", q4.size(), 0);
        check("u1_expected_left", q1.size(), 0);
        check("ui_expected_left", qi.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
